dcache_port_arbiter: RTL

Shares the single data-cache core port between two pipeline requesters: the write-back stage (memory writes, port 0) and the memory-fetch stage (operand reads, port 1). It sits between the core stages and the D-cache, grants one transaction at a time and forwards the cache request. It then routes the request acknowledge, the read response or the write acknowledge back to the owning requester. Write-back has priority, and a streak counter bounds how long reads can be starved.

---
 rtl/dcache_port_arbiter_pkg.sv | 19 +
 rtl/dcache_port_arbiter_if.sv | 51 +++++
 rtl/dcache_port_arbiter_pick.sv | 41 ++++
 rtl/dcache_port_arbiter.sv | 112 +++++++++++
 4 files changed

// File: rtl/dcache_port_arbiter_pkg.sv
// Shared state encoding, tag fields and port ids for the D-cache port arbiter.
package dcache_arb_pkg;

  typedef enum logic [1:0] {IDLE, REQ, WAIT_WRACK, WAIT_RESP} arb_state_t;

  localparam logic       READ     = 1'b0;
  localparam logic       WRITE    = 1'b1;
  localparam logic [1:0] MEMORY   = 2'b10;
  localparam logic [2:0] DATA     = 3'b001;

  localparam logic       PORT_WB  = 1'b0;
  localparam logic       PORT_MEM = 1'b1;

  // Tag layout is {rw, MEMORY, DATA, 7'b0}, 13 bits in total.
  function automatic logic [12:0] make_tag(input logic rw);
    return {rw, MEMORY, DATA, 7'b0};
  endfunction

endpackage

// File: rtl/dcache_port_arbiter_if.sv
// Requester and D-cache handshake bundle; the arbiter uses the slave view.
interface dcache_port_arbiter_if #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64,
  parameter int TAG_W  = 13
);
  logic              m0_reqcyc;
  logic [ADDR_W-1:0] m0_req;
  logic [DATA_W-1:0] m0_reqdata;
  logic [TAG_W-1:0]  m0_reqtag;
  logic              m0_reqack;
  logic              m0_writeack;

  logic              m1_reqcyc;
  logic [ADDR_W-1:0] m1_req;
  logic [TAG_W-1:0]  m1_reqtag;
  logic              m1_reqack;
  logic              m1_respcyc;
  logic [DATA_W-1:0] m1_resp;
  logic [TAG_W-1:0]  m1_resptag;
  logic              m1_respack;

  logic              c_reqcyc;
  logic [ADDR_W-1:0] c_req;
  logic [DATA_W-1:0] c_reqdata;
  logic [TAG_W-1:0]  c_reqtag;
  logic              c_reqack;
  logic              c_respcyc;
  logic [DATA_W-1:0] c_resp;
  logic [TAG_W-1:0]  c_resptag;
  logic              c_respack;
  logic              c_writeack;

  modport slave (
    input  m0_reqcyc, m0_req, m0_reqdata, m0_reqtag,
    output m0_reqack, m0_writeack,
    input  m1_reqcyc, m1_req, m1_reqtag, m1_respack,
    output m1_reqack, m1_respcyc, m1_resp, m1_resptag,
    output c_reqcyc, c_req, c_reqdata, c_reqtag, c_respack,
    input  c_reqack, c_respcyc, c_resp, c_resptag, c_writeack
  );

  modport master (
    output m0_reqcyc, m0_req, m0_reqdata, m0_reqtag,
    input  m0_reqack, m0_writeack,
    output m1_reqcyc, m1_req, m1_reqtag, m1_respack,
    input  m1_reqack, m1_respcyc, m1_resp, m1_resptag,
    input  c_reqcyc, c_req, c_reqdata, c_reqtag, c_respack,
    output c_reqack, c_respcyc, c_resp, c_resptag, c_writeack
  );
endinterface

// File: rtl/dcache_port_arbiter_pick.sv
// Grant selection between write-back and memory-fetch, with a write-streak
// counter that forces a read grant once writes have starved port 1 long enough.
module dcache_arb_pick
  import dcache_arb_pkg::*;
#(
  parameter int MAX_WR_STREAK = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic m0_reqcyc,
  input  logic m1_reqcyc,
  input  logic idle,
  output logic grant_valid,
  output logic grant_id
);

  localparam int            SW         = $clog2(MAX_WR_STREAK + 1);
  localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_WR_STREAK);

  logic [SW-1:0] streak;
  logic          starve;

  assign starve      = (streak == STREAK_MAX);
  assign grant_valid = idle && (m0_reqcyc || m1_reqcyc);
  assign grant_id    = (m1_reqcyc && (!m0_reqcyc || starve)) ? PORT_MEM : PORT_WB;

  // Only IDLE cycles matter: that is where grants are made and where an
  // absent read request resets the starvation history.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      streak <= '0;
    end else if (idle) begin
      if (!m1_reqcyc || grant_id == PORT_MEM) begin
        streak <= '0;
      end else if (!starve) begin
        streak <= streak + 1'b1;
      end
    end
  end

endmodule

// File: rtl/dcache_port_arbiter.sv
// Shares the D-cache core port between write-back (port 0) and memory-fetch
// (port 1): one transaction at a time, acks and read data routed to the owner.
module dcache_port_arbiter
  import dcache_arb_pkg::*;
#(
  parameter int ADDR_W        = 64,
  parameter int DATA_W        = 64,
  parameter int TAG_W         = 13,
  parameter int MAX_WR_STREAK = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  dcache_port_arbiter_if.slave  bus,
  output logic                  busy,
  output logic                  grant_id
);

  arb_state_t        state;
  logic              idle, in_req, in_wrack, in_resp, owner_wb;
  logic              grant_valid, pick_id;
  logic [ADDR_W-1:0] pick_req;
  logic [DATA_W-1:0] pick_data;
  logic [TAG_W-1:0]  pick_tag;

  assign idle     = (state == IDLE);
  assign in_req   = (state == REQ);
  assign in_wrack = (state == WAIT_WRACK);
  assign in_resp  = (state == WAIT_RESP);
  assign owner_wb = (grant_id == PORT_WB);

  dcache_arb_pick #(.MAX_WR_STREAK(MAX_WR_STREAK)) u_pick (
    .clk         (clk),
    .reset       (reset),
    .m0_reqcyc   (bus.m0_reqcyc),
    .m1_reqcyc   (bus.m1_reqcyc),
    .idle        (idle),
    .grant_valid (grant_valid),
    .grant_id    (pick_id)
  );

  assign pick_req  = (pick_id == PORT_MEM) ? bus.m1_req    : bus.m0_req;
  assign pick_data = (pick_id == PORT_MEM) ? '0            : bus.m0_reqdata;
  assign pick_tag  = (pick_id == PORT_MEM) ? bus.m1_reqtag : bus.m0_reqtag;

  // The request is latched at grant so a requester dropping reqcyc later
  // cannot disturb the cache-side request or cancel the transaction.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      busy          <= 1'b0;
      grant_id      <= PORT_WB;
      bus.c_reqcyc  <= 1'b0;
      bus.c_req     <= '0;
      bus.c_reqdata <= '0;
      bus.c_reqtag  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_valid) begin
            state         <= REQ;
            busy          <= 1'b1;
            grant_id      <= pick_id;
            bus.c_reqcyc  <= 1'b1;
            bus.c_req     <= pick_req;
            bus.c_reqdata <= pick_data;
            bus.c_reqtag  <= pick_tag;
          end
        end
        REQ: begin
          if (bus.c_reqack) begin
            bus.c_reqcyc <= 1'b0;
            if (!owner_wb) begin
              state <= WAIT_RESP;
            end else if (bus.c_writeack) begin
              state    <= IDLE;
              busy     <= 1'b0;
              grant_id <= PORT_WB;
            end else begin
              state <= WAIT_WRACK;
            end
          end
        end
        WAIT_WRACK: begin
          if (bus.c_writeack) begin
            state    <= IDLE;
            busy     <= 1'b0;
            grant_id <= PORT_WB;
          end
        end
        WAIT_RESP: begin
          if (bus.c_respcyc && bus.m1_respack) begin
            state    <= IDLE;
            busy     <= 1'b0;
            grant_id <= PORT_WB;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.m0_reqack   = in_req && owner_wb && bus.c_reqack;
  assign bus.m1_reqack   = in_req && !owner_wb && bus.c_reqack;
  assign bus.m0_writeack = owner_wb && bus.c_writeack && (in_wrack || (in_req && bus.c_reqack));

  // Response path is a pure pass-through, gated so stray responses are dropped.
  assign bus.m1_respcyc  = in_resp && bus.c_respcyc;
  assign bus.m1_resp     = in_resp ? bus.c_resp : '0;
  assign bus.m1_resptag  = in_resp ? bus.c_resptag : '0;
  assign bus.c_respack   = in_resp && bus.m1_respack;

endmodule
